ahb_sram_responder: RTL and testbench

//  AHB-Lite slave (responder) fronting a byte-addressable word SRAM.

---
 rtl/ahb_sram_responder_pkg.sv | 46 ++++
 rtl/ahb_sram_responder_if.sv | 26 ++
 rtl/ahb_sram_responder_bank.sv | 27 ++
 rtl/ahb_sram_responder.sv | 115 +++++++++++
 tb/tb_ahb_sram_responder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_responder_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and the byte-lane helper.
package ahb_sram_responder_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'd0,
    HtransBusy   = 2'd1,
    HtransNonseq = 2'd2,
    HtransSeq    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HsizeByte = 3'd0,
    HsizeHalf = 3'd1,
    HsizeWord = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    HburstSingle = 3'd0,
    HburstIncr   = 3'd1,
    HburstWrap4  = 3'd2,
    HburstIncr4  = 3'd3
  } hburst_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } resp_state_e;

  // Little-endian byte enables for a transfer of the given size at the given lane.
  function automatic logic [3:0] byte_enable(logic [2:0] size, logic [1:0] lane);
    logic [3:0] be;
    case (size)
      3'd0:    be = 4'b0001 << lane;
      3'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_responder_if.sv
// AHB-Lite bus bundle between one master and one responder.
interface ahb_sram_responder_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_responder_bank.sv
// DEPTH x 32 word array: one byte-enabled write port, one asynchronous read port.
module ahb_sram_responder_bank #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // Byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // Asynchronous read so a data phase sees the word in the same cycle.
  always_comb begin
    rdata = mem[raddr];
  end
endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite responder fronting a word SRAM with wait states and two-cycle ERROR.
module ahb_sram_responder
  import ahb_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = 32
) (
  input logic                 clk,
  input logic                 rst,
  ahb_sram_responder_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] AddrLimit = (ADDR_W + 1)'(DEPTH * 4);
  localparam logic [2:0] WaitLast = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  resp_state_e       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic              accept, illegal, misaligned;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;
  logic              unused_bits;

  assign mem_be      = byte_enable(size_q, addr_q[1:0]);
  assign unused_bits = ^{bus.HBURST, addr_q, size_q};

  // Address-phase qualification and legality check.
  always_comb begin
    accept     = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    misaligned = ((bus.HSIZE == 3'd1) & bus.HADDR[0]) |
                 ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00));
    illegal    = ({1'b0, bus.HADDR} >= AddrLimit) | (bus.HSIZE > 3'd2) | misaligned;
  end

  // State and address-phase registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Next state, bus responses and SRAM write strobe.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    write_d       = write_q;
    size_d        = size_q;
    mem_we        = 1'b0;
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = HRESP_OKAY;
    bus.HRDATA    = '0;
    unique case (state_q)
      StWait: begin
        bus.HREADYOUT = 1'b0;
        if (cnt_q == WaitLast) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StErr1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = HRESP_ERROR;
        state_d       = StErr2;
      end
      StIdle, StData, StErr2: begin
        if (state_q == StErr2) bus.HRESP = HRESP_ERROR;
        if (state_q == StData) begin
          mem_we = write_q;
          if (!write_q) bus.HRDATA = mem_rdata;
        end
        // Completing phase may overlap the next address phase.
        state_d = StIdle;
        if (accept) begin
          addr_d  = bus.HADDR;
          write_d = bus.HWRITE;
          size_d  = bus.HSIZE;
          cnt_d   = '0;
          if (illegal)              state_d = StErr1;
          else if (WAIT_STATES > 0) state_d = StWait;
          else                      state_d = StData;
        end
      end
    endcase
  end

  ahb_sram_responder_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .waddr (addr_q[AW+1:2]),
    .wdata (bus.HWDATA),
    .raddr (addr_q[AW+1:2]),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_ahb_sram_responder.sv
// Two responders (0 and 2 wait states) on one AHB bus; scoreboard checks each data phase.
module tb_ahb_sram_responder;
  import ahb_sram_responder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        hsel0, hsel1, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic        hready, hresp, dsel, dphase;
  logic [31:0] hrdata;

  ahb_sram_responder_if #(.ADDR_W(32)) bus0 ();
  ahb_sram_responder_if #(.ADDR_W(32)) bus1 ();

  assign bus0.HSEL = hsel0;     assign bus1.HSEL = hsel1;
  assign bus0.HADDR = haddr;    assign bus1.HADDR = haddr;
  assign bus0.HTRANS = htrans;  assign bus1.HTRANS = htrans;
  assign bus0.HWRITE = hwrite;  assign bus1.HWRITE = hwrite;
  assign bus0.HSIZE = hsize;    assign bus1.HSIZE = hsize;
  assign bus0.HBURST = hburst;  assign bus1.HBURST = hburst;
  assign bus0.HWDATA = hwdata;  assign bus1.HWDATA = hwdata;
  assign bus0.HREADY = hready;  assign bus1.HREADY = hready;

  ahb_sram_responder #(.DEPTH(256), .WAIT_STATES(0), .ADDR_W(32)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0));
  ahb_sram_responder #(.DEPTH(512), .WAIT_STATES(2), .ADDR_W(32)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1));

  // Data-phase owner mux, as a bus interconnect would do.
  assign hready = dsel ? bus1.HREADYOUT : bus0.HREADYOUT;
  assign hresp  = dsel ? bus1.HRESP : bus0.HRESP;
  assign hrdata = dsel ? bus1.HRDATA : bus0.HRDATA;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dphase <= 1'b0;
      dsel   <= 1'b0;
    end else if (hready) begin
      dphase <= (hsel0 | hsel1) & htrans[1];
      dsel   <= hsel1;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int waits_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_accept();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (hready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: HREADY stuck low at %0t", $time);
  endtask

  task automatic xfer(input bit sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic err,
                      input logic [31:0] rdata, input int waits);
    exp_t e;
    hsel0  = !sel;
    hsel1  = sel;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    haddr  = addr;
    e.err = err;
    e.rdata = rdata;
    e.waits = waits;
    sb.push_back(e);
    wait_accept();
    hwdata = wr ? wdata : 32'h0;
  endtask

  task automatic idle();
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    htrans = HtransIdle;
    wait_accept();
    hwdata = 32'h0;
  endtask

  // Scoreboard monitor: counts wait cycles, compares at each data-phase completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      waits_seen = 0;
    end else if (dphase) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_phase: data phase with empty scoreboard at %0t", $time);
      end else if (!hready) begin
        chk("wait_hresp", {31'h0, hresp}, {31'h0, sb[0].err});
        waits_seen++;
      end else begin
        e = sb.pop_front();
        chk("hresp", {31'h0, hresp}, {31'h0, e.err});
        chk("hrdata", hrdata, e.rdata);
        chk("wait_cycles", waits_seen, e.waits);
        waits_seen = 0;
      end
    end
  end

  logic [31:0] burst [4];

  initial begin
    burst[0] = 32'h11110001; burst[1] = 32'h22220002;
    burst[2] = 32'h33330003; burst[3] = 32'h44440004;
    rst = 1'b0;
    hsel0 = 0; hsel1 = 0; htrans = HtransIdle; hwrite = 0;
    hsize = HsizeWord; hburst = HburstSingle; haddr = 0; hwdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hreadyout0", {31'h0, bus0.HREADYOUT}, 32'h1);
    chk("rst_hresp0", {31'h0, bus0.HRESP}, 32'h0);
    chk("rst_hrdata0", bus0.HRDATA, 32'h0);
    chk("rst_hreadyout1", {31'h0, bus1.HREADYOUT}, 32'h1);
    chk("rst_hresp1", {31'h0, bus1.HRESP}, 32'h0);
    chk("rst_hrdata1", bus1.HRDATA, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait responder: single write then read of the same word.
    xfer(0, HtransNonseq, 1, HsizeWord, 32'h100, 32'hAABBCCDD, 0, 32'h0, 0);
    xfer(0, HtransNonseq, 0, HsizeWord, 32'h100, 32'h0, 0, 32'hAABBCCDD, 0);
    // INCR4 write and read, then WRAP4 read starting mid-block.
    hburst = HburstIncr4;
    for (int i = 0; i < 4; i++)
      xfer(0, (i == 0) ? HtransNonseq : HtransSeq, 1, HsizeWord, 32'h200 + 4 * i,
           burst[i], 0, 32'h0, 0);
    for (int i = 0; i < 4; i++)
      xfer(0, (i == 0) ? HtransNonseq : HtransSeq, 0, HsizeWord, 32'h200 + 4 * i,
           32'h0, 0, burst[i], 0);
    hburst = HburstWrap4;
    for (int i = 0; i < 4; i++)
      xfer(0, (i == 0) ? HtransNonseq : HtransSeq, 0, HsizeWord,
           32'h200 + 4 * ((i + 2) % 4), 32'h0, 0, burst[(i + 2) % 4], 0);
    hburst = HburstSingle;
    // Sub-word writes land on their own lanes only.
    xfer(0, HtransNonseq, 1, HsizeWord, 32'h300, 32'h00000000, 0, 32'h0, 0);
    xfer(0, HtransNonseq, 1, HsizeByte, 32'h301, 32'h0000FF00, 0, 32'h0, 0);
    xfer(0, HtransNonseq, 0, HsizeWord, 32'h300, 32'h0, 0, 32'h0000FF00, 0);
    xfer(0, HtransNonseq, 1, HsizeHalf, 32'h302, 32'hBEEF0000, 0, 32'h0, 0);
    xfer(0, HtransNonseq, 0, HsizeWord, 32'h300, 32'h0, 0, 32'hBEEFFF00, 0);
    idle();
    // Last legal word, then illegal accesses; memory must stay untouched.
    xfer(0, HtransNonseq, 1, HsizeWord, 32'h3FC, 32'h13579BDF, 0, 32'h0, 0);
    xfer(0, HtransNonseq, 0, HsizeWord, 32'h3FC, 32'h0, 0, 32'h13579BDF, 0);
    xfer(0, HtransNonseq, 0, HsizeWord, 32'h400, 32'h0, 1, 32'h0, 1);
    xfer(0, HtransNonseq, 1, HsizeWord, 32'h102, 32'h55555555, 1, 32'h0, 1);
    xfer(0, HtransNonseq, 1, HsizeHalf, 32'h101, 32'h55555555, 1, 32'h0, 1);
    xfer(0, HtransNonseq, 0, 3'd3, 32'h100, 32'h0, 1, 32'h0, 1);
    xfer(0, HtransNonseq, 0, HsizeWord, 32'h100, 32'h0, 0, 32'hAABBCCDD, 0);
    // Burst abandoned after two beats.
    hburst = HburstIncr4;
    xfer(0, HtransNonseq, 1, HsizeWord, 32'h10, 32'h01010101, 0, 32'h0, 0);
    xfer(0, HtransSeq, 1, HsizeWord, 32'h14, 32'h02020202, 0, 32'h0, 0);
    idle();
    hburst = HburstSingle;
    xfer(0, HtransNonseq, 0, HsizeWord, 32'h14, 32'h0, 0, 32'h02020202, 0);

    // Two-wait responder.
    xfer(1, HtransNonseq, 1, HsizeWord, 32'h200, 32'h0A0B0C0D, 0, 32'h0, 2);
    xfer(1, HtransNonseq, 0, HsizeWord, 32'h200, 32'h0, 0, 32'h0A0B0C0D, 2);
    xfer(1, HtransNonseq, 0, HsizeWord, 32'h800, 32'h0, 1, 32'h0, 1);
    xfer(1, HtransNonseq, 1, HsizeWord, 32'h400, 32'hCAFEF00D, 0, 32'h0, 2);
    idle();
    // Reset lands during the wait of a second write to the same word.
    xfer(1, HtransNonseq, 1, HsizeWord, 32'h400, 32'hDEADBEEF, 0, 32'h0, 2);
    hsel1 = 1'b0;
    htrans = HtransIdle;
    chk("wait_hreadyout", {31'h0, bus1.HREADYOUT}, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_hreadyout", {31'h0, bus1.HREADYOUT}, 32'h1);
    chk("rst_mid_hresp", {31'h0, bus1.HRESP}, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    xfer(1, HtransNonseq, 0, HsizeWord, 32'h400, 32'h0, 0, 32'hCAFEF00D, 2);
    idle();

    for (int n = 0; n < 50 && sb.size() > 0; n++) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
